bin_to_st_converter: RTL
========================

# bin_to_st_converter

Binary-to-stochastic converter: accepts an 8-bit unsigned value and emits a 256-bit unipolar stochastic bitstream whose ones-count equals that value exactly. Each bit is produced by comparing a pseudo-random 8-bit value against the captured input. The bitstream is delivered two ways: serially, one bit per cycle, and as a 256-bit parallel vector. The parallel vector feeds the stochastic-to-binary counter directly. The block sits at the input edge of the stochastic datapath.

## Interface
Parameters:
- DEFAULT_SEED, 8'hA5, LFSR seed substituted when `seed` is 0; must be non-zero.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  `bin`/`seed` valid.
- in_ready  out  1  converter can accept; equals (state==IDLE) && rst_n.
- bin  in  8  unsigned value to encode (0..255).
- seed  in  8  LFSR start state for this conversion.
- st_valid  out  1  high on each cycle a serial bit is presented.
- st_bit  out  1  current serial stochastic bit.
- out_valid  out  1  parallel vector complete and held.
- out_ready  in  1  downstream consumes vector.
- st  out  256  parallel bitstream; `st[k]` is the k-th serial bit.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on in_valid && in_ready.
  - RUN → DONE after idx 255.
  - DONE → IDLE on out_ready.
- On accept:
  - bin_q ← bin.
  - lfsr ← (seed==0 ? DEFAULT_SEED : seed).
  - idx ← 0.
- RUN, per cycle:
  - r = (idx==255) ? 8'h00 : lfsr.
  - st_bit = (r < bin_q), compared as unsigned.
  - st_valid = 1.
  - At the edge: st[idx] ← st_bit, lfsr ← next(lfsr), idx ← idx+1 (8-bit, wraps to 0 at leaving RUN).
- LFSR: Fibonacci, left shift, next(s) = {s[6:0], s[7]^s[5]^s[4]^s[3]}. Polynomial x^8+x^6+x^5+x^4+1, maximal length 255.
  - The 255 LFSR states plus the forced 0 at idx 255 cover 0..255 exactly once.
  - Therefore popcount(st) == bin_q, exactly, for every seed.
- DONE:
  - out_valid=1; `st` held stable.
  - in_valid ignored.
  - Handshake completes on out_valid && out_ready.
- Outside RUN: st_valid=0, st_bit=0.
- `st` is not cleared between conversions; every bit is overwritten during RUN.

## Timing
- Reset (rst_n low at an edge):
  - state ← IDLE, idx ← 0, lfsr ← DEFAULT_SEED, bin_q ← 0, st ← 0.
  - All outputs 0 while rst_n is low, including in_ready.
- Accept at edge T:
  - Serial bits on cycles T+1..T+256 (bit k in cycle T+1+k).
  - out_valid first high in cycle T+257.
- Minimum period between accepts: 258 cycles (DONE ≥1 cycle, IDLE ≥1 cycle). No accept in DONE, even when out_ready is high.
- Serial output has no backpressure; it is valid only when st_valid is high.
- Reset mid-RUN or in DONE: conversion aborted, no out_valid. in_ready is high on the first cycle after rst_n returns high.
- in_valid held high with in_ready low: inputs not sampled; the value is captured only on the accepting edge.
- Changing bin or seed during RUN has no effect.

## Structure
- Package `sc_pkg`:
  - localparam SC_N=8, SC_LEN=256.
  - LFSR tap mask 8'hB8.
  - typedef enum {IDLE, RUN, DONE} for the FSM state.
  - function `lfsr8_next`.
- Sub-module `sc_lfsr8`: load, enable, and 8-bit state output, using `lfsr8_next`.
- Top level holds the FSM, idx counter, comparator and 256-bit vector register.

## Test plan
- bin=0, seed=1 → st_bit=0 for all 256 cycles; st==0; out_valid at T+257.
- bin=255, seed=1 → exactly 255 ones; the single zero is at the index where lfsr==8'hFF; st[255]==1.
- bin=128, seed=8'h3C → popcount(st)==128; serial bits equal st[k] in order; st_valid high for exactly 256 cycles.
- seed=0, bin=77 → output identical to a run with seed=DEFAULT_SEED, bin=77; popcount 77.
- out_ready held low 10 cycles in DONE with in_valid=1 and a new bin → st and out_valid stable, in_ready=0, nothing accepted; out_ready=1 → IDLE on the next cycle.
- rst_n low at idx 100 → next cycle st_valid=0, st==0, out_valid=0; after release, in_ready=1 and a new bin=10 conversion yields popcount 10.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing datapath.
// LFSR taps, stream sizes and the converter FSM state type.
package sc_pkg;

  localparam int SC_N   = 8;
  localparam int SC_LEN = 256;

  localparam logic [SC_N-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sc_state_e;

  // Taps 7,5,4,3 give x^8+x^6+x^5+x^4+1, a maximal 255-state sequence.
  function automatic logic [SC_N-1:0] lfsr8_next(
    input logic [SC_N-1:0] s
  );
    return {s[SC_N-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sc_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous load and step enable.
// Load takes priority over stepping.
module sc_lfsr8
  import sc_pkg::*;
#(
  parameter logic [SC_N-1:0] SEED = 8'hA5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            en_i,
  input  logic [SC_N-1:0] load_val_i,
  output logic [SC_N-1:0] state_o
);

  logic [SC_N-1:0] lfsr_q;
  logic [SC_N-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = load_val_i;
    end else if (en_i) begin
      lfsr_d = lfsr8_next(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/bin_to_st_converter.sv
// Binary-to-stochastic converter: 8-bit value to a 256-bit unipolar
// stream with an exact ones-count, delivered serially and in parallel.
module bin_to_st_converter
  import sc_pkg::*;
#(
  parameter logic [SC_N-1:0] DEFAULT_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SC_N-1:0]   bin,
  input  logic [SC_N-1:0]   seed,
  output logic              st_valid,
  output logic              st_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SC_LEN-1:0] st
);

  sc_state_e         state_q, state_d;
  logic [SC_N-1:0]   idx_q, idx_d;
  logic [SC_N-1:0]   bin_q, bin_d;
  logic [SC_LEN-1:0] st_q;
  logic [SC_N-1:0]   lfsr;
  logic [SC_N-1:0]   seed_eff;
  logic [SC_N-1:0]   r;
  logic              accept;
  logic              step;
  logic              cmp;

  assign seed_eff = (seed == '0) ? DEFAULT_SEED : seed;

  sc_lfsr8 #(
    .SEED (DEFAULT_SEED)
  ) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .en_i       (step),
    .load_val_i (seed_eff),
    .state_o    (lfsr)
  );

  // The LFSR never reaches 0, so forcing 0 on the last slot
  // completes the 0..255 permutation and makes the count exact.
  assign r   = (idx_q == 8'hFF) ? '0 : lfsr;
  assign cmp = r < bin_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bin_d   = bin_q;
    accept  = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept  = 1'b1;
          bin_d   = bin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        step  = 1'b1;
        idx_d = idx_q + 8'd1;
        if (idx_q == 8'hFF) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bin_q   <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bin_q   <= bin_d;
      if (step) begin
        st_q[idx_q] <= cmp;
      end
    end
  end

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign st_valid  = (state_q == RUN) && rst_n;
  assign st_bit    = st_valid && cmp;
  assign out_valid = (state_q == DONE) && rst_n;
  assign st        = rst_n ? st_q : '0;

endmodule
